// File: rtl/multi_srambank.sv
// DEPTH x DATA 1R1W register-file bank with post-reset zero-fill and RD_LAT (1 or 2) read pipeline.
// Optional macro SRAMBANK_WR_BYPASS_EN enables write-to-read forwarding for same-address collisions.
module multi_srambank #(
  parameter int unsigned DATA   = 18,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR   = 4,
  parameter int unsigned RD_LAT = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_bank_sel,
  input  logic            i_write_en,
  input  logic [ADDR-1:0] i_write_addr,
  input  logic [DATA-1:0] i_write_data,
  input  logic            i_read_en,
  input  logic [ADDR-1:0] i_read_addr,
  output logic [DATA-1:0] o_data_out,
  output logic            o_data_valid,
  output logic            o_ready
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [ADDR-1:0] LAST_IDX = ADDR'(DEPTH - 1);
  localparam logic [ADDR:0]   DEPTH_W  = (ADDR + 1)'(DEPTH);

  state_t          state_q, state_d;
  logic [ADDR-1:0] init_cnt_q, init_cnt_d;
  logic [DATA-1:0] mem [DEPTH];
  logic            wr_acc, rd_acc, rd_in_range;
  logic [DATA-1:0] rd_word;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    o_ready    = (state_q == ST_RUN);
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == LAST_IDX) state_d = ST_RUN;
    end
  end

  always_comb begin
    rd_in_range = ({1'b0, i_read_addr} < DEPTH_W);
    wr_acc      = i_bank_sel & i_write_en & o_ready & ({1'b0, i_write_addr} < DEPTH_W);
    rd_acc      = i_bank_sel & i_read_en & o_ready;
    rd_word     = rd_in_range ? mem[i_read_addr] : '0;
`ifdef SRAMBANK_WR_BYPASS_EN
    if (wr_acc && (i_write_addr == i_read_addr)) rd_word = i_write_data;
`endif
  end

  // Array has no reset: the INIT sweep is what clears it.
  always_ff @(posedge i_clk) begin
    if (state_q == ST_INIT) begin
      mem[init_cnt_q] <= '0;
    end else if (wr_acc) begin
      mem[i_write_addr] <= i_write_data;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic            s1_valid;
    logic [DATA-1:0] s1_data, s1_fwd;
`ifdef SRAMBANK_WR_BYPASS_EN
    logic [ADDR-1:0] s1_addr;
`endif

    always_comb begin
      s1_fwd = s1_data;
`ifdef SRAMBANK_WR_BYPASS_EN
      if (wr_acc && (i_write_addr == s1_addr)) s1_fwd = i_write_data;
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        s1_valid     <= 1'b0;
        s1_data      <= '0;
`ifdef SRAMBANK_WR_BYPASS_EN
        s1_addr      <= '0;
`endif
        o_data_out   <= '0;
        o_data_valid <= 1'b0;
      end else begin
        s1_valid <= rd_acc;
        if (rd_acc) begin
          s1_data <= rd_word;
`ifdef SRAMBANK_WR_BYPASS_EN
          s1_addr <= i_read_addr;
`endif
        end
        o_data_valid <= s1_valid;
        if (s1_valid) o_data_out <= s1_fwd;
      end
    end
  end else begin : g_lat1
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        o_data_out   <= '0;
        o_data_valid <= 1'b0;
      end else begin
        o_data_valid <= rd_acc;
        if (rd_acc) o_data_out <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_multi_srambank.sv
// Bench for multi_srambank: instance A (DEPTH 16, RD_LAT 1) and B (DEPTH 12, RD_LAT 2) share stimulus;
// a due-time scoreboard model is checked every cycle, plus directed literal checks.
module tb_multi_srambank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0, wen = 1'b0, ren = 1'b0;
  logic [3:0]  waddr = '0, raddr = '0;
  logic [17:0] wdata = '0;
  logic [17:0] dout [2];
  logic        dval [2];
  logic        drdy [2];

  int checks = 0;
  int failures = 0;

`ifdef SRAMBANK_WR_BYPASS_EN
  localparam logic [17:0] EXP_SAME = 18'h12345;
  localparam logic [17:0] EXP_NEXT = 18'h15555;
`else
  localparam logic [17:0] EXP_SAME = 18'h00001;
  localparam logic [17:0] EXP_NEXT = 18'h00107;
`endif

  always #5 clk = ~clk;

  multi_srambank #(.DATA(18), .DEPTH(16), .ADDR(4), .RD_LAT(1)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_bank_sel(sel), .i_write_en(wen),
    .i_write_addr(waddr), .i_write_data(wdata), .i_read_en(ren), .i_read_addr(raddr),
    .o_data_out(dout[0]), .o_data_valid(dval[0]), .o_ready(drdy[0]));

  multi_srambank #(.DATA(18), .DEPTH(12), .ADDR(4), .RD_LAT(2)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_bank_sel(sel), .i_write_en(wen),
    .i_write_addr(waddr), .i_write_data(wdata), .i_read_en(ren), .i_read_addr(raddr),
    .o_data_out(dout[1]), .o_data_valid(dval[1]), .o_ready(drdy[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: per-instance memory image and a table of pending reads keyed by the edge they complete on.
  int          DEP [2] = '{16, 12};
  int          LAT [2] = '{1, 2};
  int          ecnt;
  logic [17:0] mm [2][16];
  bit          pv [2][4];
  int          pdue [2][4];
  int          paddr [2][4];
  logic [17:0] pdat [2][4];
  logic        exp_ready [2], exp_valid [2];
  logic [17:0] exp_data [2];

  always @(posedge clk) begin
    int s;
    bit rdy;
    if (!rst_n) begin
      ecnt = 0;
      for (int k = 0; k < 2; k++) begin
        exp_ready[k] = 0; exp_valid[k] = 0; exp_data[k] = '0;
        for (int j = 0; j < 4; j++) pv[k][j] = 0;
        for (int a = 0; a < 16; a++) mm[k][a] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        rdy = (ecnt >= DEP[k]);
        if (sel && ren && rdy) begin
          s = (ecnt + LAT[k] - 1) % 4;
          pv[k][s] = 1;
          pdue[k][s] = ecnt + LAT[k] - 1;
          paddr[k][s] = int'(raddr);
          pdat[k][s] = (int'(raddr) < DEP[k]) ? mm[k][raddr] : '0;
        end
        if (sel && wen && rdy && int'(waddr) < DEP[k]) mm[k][waddr] = wdata;
        exp_valid[k] = 0;
        s = ecnt % 4;
        if (pv[k][s] && pdue[k][s] == ecnt) begin
          exp_valid[k] = 1;
`ifdef SRAMBANK_WR_BYPASS_EN
          exp_data[k] = (paddr[k][s] < DEP[k]) ? mm[k][paddr[k][s]] : '0;
`else
          exp_data[k] = pdat[k][s];
`endif
          pv[k][s] = 0;
        end
        exp_ready[k] = ((ecnt + 1) >= DEP[k]);
      end
      ecnt++;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        chk($sformatf("rst_ready%0d", k), 32'(drdy[k]), 32'd0);
        chk($sformatf("rst_valid%0d", k), 32'(dval[k]), 32'd0);
        chk($sformatf("rst_data%0d", k), 32'(dout[k]), 32'd0);
      end else begin
        chk($sformatf("ready%0d", k), 32'(drdy[k]), 32'(exp_ready[k]));
        chk($sformatf("valid%0d", k), 32'(dval[k]), 32'(exp_valid[k]));
        chk($sformatf("data%0d", k), 32'(dout[k]), 32'(exp_data[k]));
      end
    end
  end

  logic [17:0] capA [$];
  logic [17:0] capB [$];

  always @(negedge clk) begin
    if (dval[0]) capA.push_back(dout[0]);
    if (dval[1]) capB.push_back(dout[1]);
  end

  function automatic logic [17:0] qa(input int i);
    return (capA.size() > i) ? capA[i] : 'x;
  endfunction

  function automatic logic [17:0] qb(input int i);
    return (capB.size() > i) ? capB[i] : 'x;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 0; ren = 0; sel = 1;
  endtask

  task automatic clearq();
    capA.delete();
    capB.delete();
  endtask

  task automatic wait_ready(output int na, output int nb);
    na = 0; nb = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (na == 0 && drdy[0]) na = n;
      if (nb == 0 && drdy[1]) nb = n;
      if (na != 0 && nb != 0) break;
    end
  endtask

  initial begin
    int na, nb;
    repeat (3) step();
    chk("reset_data_A", 32'(dout[0]), 32'd0);
    chk("reset_ready_A", 32'(drdy[0]), 32'd0);
    chk("reset_valid_B", 32'(dval[1]), 32'd0);

    // 1: init length, with reads requested during init
    rst_n = 1; sel = 1; ren = 1; raddr = 4'd0;
    wait_ready(na, nb);
    chk("init_len_A", 32'(na), 32'd16);
    chk("init_len_B", 32'(nb), 32'd12);
    idle(); repeat (3) step();
    clearq();
    for (int i = 0; i < 16; i++) begin
      ren = 1; raddr = 4'(i); step();
    end
    idle(); repeat (3) step();
    chk("zero_cnt_A", 32'(capA.size()), 32'd16);
    chk("zero_cnt_B", 32'(capB.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("zero_A", 32'(qa(i)), 32'd0);
      chk("zero_B", 32'(qb(i)), 32'd0);
    end

    // 2: write then read, latency per instance
    wen = 1; waddr = 4'd5; wdata = 18'h3ABCD; step();
    wen = 0; ren = 1; raddr = 4'd5; step();
    ren = 0;
    chk("lat_A_valid", 32'(dval[0]), 32'd1);
    chk("lat_A_data", 32'(dout[0]), 32'h3ABCD);
    chk("lat_B_early", 32'(dval[1]), 32'd0);
    step();
    chk("lat_A_pulse", 32'(dval[0]), 32'd0);
    chk("lat_B_valid", 32'(dval[1]), 32'd1);
    chk("lat_B_data", 32'(dout[1]), 32'h3ABCD);

    // 3: same-cycle same-address collision
    wen = 1; waddr = 4'd3; wdata = 18'h00001; step();
    wdata = 18'h12345; ren = 1; raddr = 4'd3; step();
    idle();
    chk("coll_A", 32'(dout[0]), 32'(EXP_SAME));
    step();
    chk("coll_B_valid", 32'(dval[1]), 32'd1);
    chk("coll_B", 32'(dout[1]), 32'(EXP_SAME));

    // 4: pattern fill, back-to-back reads, then bank_sel low
    for (int i = 0; i < 16; i++) begin
      wen = 1; waddr = 4'(i); wdata = 18'h00100 + 18'(i); step();
    end
    idle(); step(); clearq();
    for (int i = 0; i < 16; i++) begin
      ren = 1; raddr = 4'(i); step();
    end
    idle(); repeat (3) step();
    chk("b2b_cnt_A", 32'(capA.size()), 32'd16);
    chk("b2b_cnt_B", 32'(capB.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("b2b_A", 32'(qa(i)), 32'h100 + 32'(i));
      chk("b2b_B", 32'(qb(i)), (i < 12) ? 32'h100 + 32'(i) : 32'd0);
    end
    clearq();
    sel = 0; wen = 1; waddr = 4'd0; wdata = 18'h2FFFF; ren = 1; raddr = 4'd0; step();
    idle(); repeat (3) step();
    chk("nosel_A", 32'(capA.size()), 32'd0);
    chk("nosel_B", 32'(capB.size()), 32'd0);
    ren = 1; raddr = 4'd0; step();
    idle(); repeat (3) step();
    chk("nosel_keep_A", 32'(qa(0)), 32'h100);
    chk("nosel_keep_B", 32'(qb(0)), 32'h100);

    // 5: address beyond DEPTH on B
    clearq();
    wen = 1; waddr = 4'd13; wdata = 18'h2AAAA; step();
    wen = 0; ren = 1; raddr = 4'd13; step();
    idle(); repeat (3) step();
    chk("oor_A", 32'(qa(0)), 32'h2AAAA);
    chk("oor_B_cnt", 32'(capB.size()), 32'd1);
    chk("oor_B", 32'(qb(0)), 32'd0);

    // write in the cycle after a read accept, same address
    clearq();
    ren = 1; raddr = 4'd7; step();
    ren = 0; wen = 1; waddr = 4'd7; wdata = 18'h15555; step();
    idle(); repeat (3) step();
    chk("next_A", 32'(qa(0)), 32'h107);
    chk("next_B", 32'(qb(0)), 32'(EXP_NEXT));

    // 6: reset with reads in flight
    ren = 1; raddr = 4'd1; step();
    clearq();
    raddr = 4'd2;
    #3 rst_n = 0;
    ren = 0;
    repeat (3) step();
    chk("flush_A", 32'(capA.size()), 32'd0);
    chk("flush_B", 32'(capB.size()), 32'd0);
    rst_n = 1;
    wait_ready(na, nb);
    chk("reinit_A", 32'(na), 32'd16);
    chk("reinit_B", 32'(nb), 32'd12);
    ren = 1; raddr = 4'd10; step();
    idle(); repeat (3) step();
    chk("lost_cnt_A", 32'(capA.size()), 32'd1);
    chk("lost_A", 32'(qa(0)), 32'd0);
    chk("lost_B", 32'(qb(0)), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
